// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory fetch bus: req/addr from the fetch stage, ack/rdata from memory.
interface pc_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch stage side: issues requests, consumes returned words.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side: answers requests.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// Program-counter register and instruction-fetch controller.
// Holds the current PC, fetches the instruction at that PC over a req/ack
// handshake, and exposes PC+4 and the jump target for the next-PC mux.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  MAX_WAIT = 8'd15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        choose_pc,
  input  logic               pc_write,
  pc_fetch_stage_if.master   mem,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        j_concat,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               fetch_fault
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t              state;
  logic                req_q;
  logic [WAIT_W-1:0]   wait_cnt;

  // Address and next-PC candidates derive directly from the PC register.
  assign mem.imem_req  = req_q;
  assign mem.imem_addr = pc;
  assign pc_plus4      = pc + 32'd4;
  assign j_concat      = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Fetch FSM: boot, fetch with ack timeout, wait for pc_write, sticky fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_q       <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          req_q    <= 1'b1;
          wait_cnt <= '0;
        end

        FETCH: begin
          if (mem.imem_ack) begin
            instr       <= mem.imem_rdata;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= EXEC;
          end else begin
            wait_cnt <= WAIT_W'(wait_cnt + WAIT_W'(1));
            if (wait_cnt == MAX_WAIT) begin
              fetch_fault <= 1'b1;
              req_q       <= 1'b0;
              state       <= FAULT;
            end
          end
        end

        EXEC: begin
          if (pc_write) begin
            instr_valid <= 1'b0;
            if (choose_pc[1:0] == 2'b00) begin
              pc       <= choose_pc;
              req_q    <= 1'b1;
              wait_cnt <= '0;
              state    <= FETCH;
            end else begin
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end
          end
        end

        FAULT: begin
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
        end

        default: begin
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
          fetch_fault <= 1'b1;
          state       <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: cycle table for boot/sequential/jump/wait
// states, plus hand-written timeout, misaligned, async-reset and wrap sequences.
module tb_pc_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [7:0]  MW     = 8'd15;

  logic        clk;
  logic        reset_n;
  logic [31:0] choose_pc;
  logic        pc_write;
  logic [31:0] pc, pc_plus4, j_concat, instr;
  logic        instr_valid, fetch_fault;

  int errors = 0;
  int checks = 0;

  pc_fetch_stage_if bus();

  pc_fetch_stage #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .choose_pc   (choose_pc),
    .pc_write    (pc_write),
    .mem         (bus),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .j_concat    (j_concat),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic [31:0] cpc;
    logic        ack;
    logic [31:0] rd;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_fault;
    logic [31:0] e_jc;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1ns after the rising edge.
  task automatic step(input logic pw, input logic [31:0] cpc, input logic ack, input logic [31:0] rd);
    pc_write       = pw;
    choose_pc      = cpc;
    bus.imem_ack   = ack;
    bus.imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  // Hold reset over one edge, release 1ns after an edge.
  task automatic boot();
    reset_n        = 1'b0;
    pc_write       = 1'b0;
    choose_pc      = 32'h0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            pw   cpc           ack  rd            e_pc          req  val  e_instr       flt  e_jc
    vt[0]  = '{1'b0, 32'h0,        1'b1, 32'h2008_0005, 32'h0040_0000, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0000};
    vt[1]  = '{1'b0, 32'h0,        1'b1, 32'h2008_0005, 32'h0040_0000, 1'b0, 1'b1, 32'h2008_0005, 1'b0, 32'h0020_0014};
    vt[2]  = '{1'b1, 32'h0040_0004, 1'b0, 32'h0,        32'h0040_0004, 1'b1, 1'b0, 32'h2008_0005, 1'b0, 32'h0020_0014};
    vt[3]  = '{1'b0, 32'h0,        1'b0, 32'h0,         32'h0040_0004, 1'b1, 1'b0, 32'h2008_0005, 1'b0, 32'h0020_0014};
    vt[4]  = '{1'b0, 32'h0,        1'b1, 32'h0000_0020, 32'h0040_0004, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0080};
    vt[5]  = '{1'b1, 32'h0040_0008, 1'b0, 32'h0,        32'h0040_0008, 1'b1, 1'b0, 32'h0000_0020, 1'b0, 32'h0000_0080};
    vt[6]  = '{1'b0, 32'h0,        1'b1, 32'h0810_0010, 32'h0040_0008, 1'b0, 1'b1, 32'h0810_0010, 1'b0, 32'h0040_0040};
    vt[7]  = '{1'b1, 32'h0040_0040, 1'b0, 32'h0,        32'h0040_0040, 1'b1, 1'b0, 32'h0810_0010, 1'b0, 32'h0040_0040};
    vt[8]  = '{1'b1, 32'h1111_0000, 1'b0, 32'h0,        32'h0040_0040, 1'b1, 1'b0, 32'h0810_0010, 1'b0, 32'h0040_0040};
    vt[9]  = '{1'b0, 32'h0,        1'b0, 32'h0,         32'h0040_0040, 1'b1, 1'b0, 32'h0810_0010, 1'b0, 32'h0040_0040};
    vt[10] = '{1'b0, 32'h0,        1'b0, 32'h0,         32'h0040_0040, 1'b1, 1'b0, 32'h0810_0010, 1'b0, 32'h0040_0040};
    vt[11] = '{1'b0, 32'h0,        1'b0, 32'h0,         32'h0040_0040, 1'b1, 1'b0, 32'h0810_0010, 1'b0, 32'h0040_0040};
    vt[12] = '{1'b0, 32'h0,        1'b0, 32'h0,         32'h0040_0040, 1'b1, 1'b0, 32'h0810_0010, 1'b0, 32'h0040_0040};
    vt[13] = '{1'b0, 32'h0,        1'b1, 32'h8C08_0000, 32'h0040_0040, 1'b0, 1'b1, 32'h8C08_0000, 1'b0, 32'h0020_0000};

    // Reset state
    reset_n        = 1'b0;
    pc_write       = 1'b0;
    choose_pc      = 32'h0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    @(posedge clk);
    #1;
    chk("rst_pc",    pc,                  RST_PC);
    chk("rst_addr",  bus.imem_addr,       RST_PC);
    chk("rst_req",   32'(bus.imem_req),   32'd0);
    chk("rst_instr", instr,               32'h0);
    chk("rst_valid", 32'(instr_valid),    32'd0);
    chk("rst_fault", 32'(fetch_fault),    32'd0);
    chk("rst_p4",    pc_plus4,            32'h0040_0004);
    reset_n = 1'b1;

    // Boot, sequential, jump, 5-cycle wait states
    for (int i = 0; i < 14; i++) begin
      step(vt[i].pw, vt[i].cpc, vt[i].ack, vt[i].rd);
      chk($sformatf("v%0d_pc", i),    pc,                vt[i].e_pc);
      chk($sformatf("v%0d_addr", i),  bus.imem_addr,     vt[i].e_pc);
      chk($sformatf("v%0d_req", i),   32'(bus.imem_req), 32'(vt[i].e_req));
      chk($sformatf("v%0d_valid", i), 32'(instr_valid),  32'(vt[i].e_valid));
      chk($sformatf("v%0d_instr", i), instr,             vt[i].e_instr);
      chk($sformatf("v%0d_fault", i), 32'(fetch_fault),  32'(vt[i].e_fault));
      chk($sformatf("v%0d_jc", i),    j_concat,          vt[i].e_jc);
    end

    // Ack timeout: MAX_WAIT no-ack edges are tolerated, the next one faults
    step(1'b1, 32'h0040_0044, 1'b0, 32'h0);
    chk("to_start_req", 32'(bus.imem_req), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
    chk("to_15_fault", 32'(fetch_fault),  32'd0);
    chk("to_15_req",   32'(bus.imem_req), 32'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0);
    chk("to_16_fault", 32'(fetch_fault),  32'd1);
    chk("to_16_req",   32'(bus.imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
      chk($sformatf("to_stick%0d_fault", i), 32'(fetch_fault),  32'd1);
      chk($sformatf("to_stick%0d_req", i),   32'(bus.imem_req), 32'd0);
      chk($sformatf("to_stick%0d_valid", i), 32'(instr_valid),  32'd0);
      chk($sformatf("to_stick%0d_pc", i),    pc,                32'h0040_0044);
      chk($sformatf("to_stick%0d_instr", i), instr,             32'h8C08_0000);
    end

    // Misaligned next PC faults without moving pc
    boot();
    chk("ma_boot_fault", 32'(fetch_fault), 32'd0);
    step(1'b0, 32'h0, 1'b1, 32'h0000_0020);
    step(1'b0, 32'h0, 1'b1, 32'h0000_0020);
    chk("ma_exec_valid", 32'(instr_valid), 32'd1);
    step(1'b1, 32'h0040_0006, 1'b0, 32'h0);
    chk("ma_fault", 32'(fetch_fault),  32'd1);
    chk("ma_pc",    pc,                32'h0040_0000);
    chk("ma_valid", 32'(instr_valid),  32'd0);
    chk("ma_req",   32'(bus.imem_req), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h0040_0010, 1'b1, 32'h1234_5678);
      chk($sformatf("ma_hold%0d_req", i), 32'(bus.imem_req), 32'd0);
      chk($sformatf("ma_hold%0d_pc", i),  pc,                32'h0040_0000);
    end

    // Async reset mid-fetch, then the held ack is not taken from IDLE
    boot();
    step(1'b0, 32'h0, 1'b1, 32'h0000_0020);
    step(1'b0, 32'h0, 1'b1, 32'h0000_0020);
    step(1'b1, 32'h0040_0004, 1'b0, 32'h0);
    chk("ar_pre_req", 32'(bus.imem_req), 32'd1);
    chk("ar_pre_pc",  pc,                32'h0040_0004);
    #2;
    reset_n = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hCAFE_F00D;
    #1;
    chk("ar_req",   32'(bus.imem_req), 32'd0);
    chk("ar_pc",    pc,                RST_PC);
    chk("ar_instr", instr,             32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
    chk("ar_idle_req",   32'(bus.imem_req), 32'd1);
    chk("ar_idle_valid", 32'(instr_valid),  32'd0);
    chk("ar_idle_instr", instr,             32'h0);
    step(1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
    chk("ar_fetch_instr", instr,            32'hCAFE_F00D);

    // PC wrap at the top of the address space
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("wr_pc",    pc,                32'hFFFF_FFFC);
    chk("wr_addr",  bus.imem_addr,     32'hFFFF_FFFC);
    chk("wr_p4",    pc_plus4,          32'h0000_0000);
    chk("wr_fault", 32'(fetch_fault),  32'd0);
    step(1'b0, 32'h0, 1'b1, 32'h0BFF_FFFF);
    chk("wr_valid", 32'(instr_valid),  32'd1);
    chk("wr_jc",    j_concat,          32'h0FFF_FFFC);
    chk("wr_fault2", 32'(fetch_fault), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
